// File: rtl/scrambler_xor_6.sv
// Keystream XOR stage: scrambles 14-bit beats with the top of the LFSR state,
// buffers them in a 2-entry main/skid pair and keeps saturating status counters.
module scrambler_xor_6 #(
    parameter int DATA_WIDTH = 14,
    parameter int POLY_WIDTH = 84,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [POLY_WIDTH-1:0] lfsr_dout,
    output logic                  lfsr_enable,
    input  logic                  scr_bypass,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        if (val == {CNT_WIDTH{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    logic                  accept_s;
    logic                  drain_s;
    logic [DATA_WIDTH-1:0] ks_s;
    logic [DATA_WIDTH-1:0] word_s;

    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
    logic                  main_last_q,  main_last_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  skid_last_q,  skid_last_d;
    logic                  in_ready_q,   in_ready_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q,   beat_cnt_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q,  frame_cnt_d;

    // Next-state logic for the main/skid buffer, ready flag and counters
    always_comb begin
        ks_s     = lfsr_dout[POLY_WIDTH-1 -: DATA_WIDTH];
        accept_s = in_valid & in_ready_q;
        drain_s  = main_valid_q & out_ready;
        if (scr_bypass) begin
            word_s = in_data;
        end else begin
            word_s = in_data ^ ks_s;
        end
        lfsr_enable = accept_s & ~scr_bypass & ~rst;

        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;

        case ({drain_s, accept_s})
            2'b00: begin
                main_valid_d = main_valid_q;
            end
            2'b01: begin
                if (!main_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = word_s;
                    main_last_d  = in_last;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = word_s;
                    skid_last_d  = in_last;
                end
            end
            2'b10: begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    main_last_d  = skid_last_q;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = 1'b0;
                end
            end
            2'b11: begin
                // Skid keeps FIFO order: an arrival during a skid->main move lands in skid
                if (skid_valid_q) begin
                    main_data_d = skid_data_q;
                    main_last_d = skid_last_q;
                    skid_data_d = word_s;
                    skid_last_d = in_last;
                end else begin
                    main_data_d = word_s;
                    main_last_d = in_last;
                end
            end
            default: begin
                main_valid_d = main_valid_q;
            end
        endcase

        in_ready_d = ~skid_valid_d;

        if (cnt_clr) begin
            beat_cnt_d  = {CNT_WIDTH{1'b0}};
            frame_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                beat_cnt_d = sat_inc(beat_cnt_q);
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
            if (accept_s && in_last) begin
                frame_cnt_d = sat_inc(frame_cnt_q);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= {DATA_WIDTH{1'b0}};
            main_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_WIDTH{1'b0}};
            skid_last_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            beat_cnt_q   <= {CNT_WIDTH{1'b0}};
            frame_cnt_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            in_ready_q   <= in_ready_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_last  = main_last_q;
    assign beat_cnt  = beat_cnt_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_scrambler_xor_6.sv
// Bench for scrambler_xor_6: a table-driven keystream source plus a FIFO
// reference model checked every cycle, with directed scenarios and random traffic.
module tb_scrambler_xor_6;

    logic        clk = 1'b0;
    logic        rst;
    logic [83:0] lfsr_dout;
    logic        lfsr_enable;
    logic        scr_bypass;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic        out_last;
    logic        cnt_clr;
    logic [15:0] beat_cnt;
    logic [15:0] frame_cnt;

    scrambler_xor_6 dut (
        .clk         (clk),
        .rst         (rst),
        .lfsr_dout   (lfsr_dout),
        .lfsr_enable (lfsr_enable),
        .scr_bypass  (scr_bypass),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .cnt_clr     (cnt_clr),
        .beat_cnt    (beat_cnt),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // Keystream source: each enable pulse steps to the next table entry
    logic [83:0] ks_tab [2048];
    int          gen_idx;
    int          ks_idx;
    int          en_pulses;

    // Reference model state
    logic [14:0] exp_q [$];
    logic        m_ready;
    int          m_beat;
    int          m_frame;

    int n_checks;
    int n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [13:0] d, input logic l, input logic byp,
                        input logic ordy, input logic clr, input logic r);
        logic        acc;
        logic        en;
        logic [13:0] word;
        logic [14:0] head;
        rst        = r;
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        scr_bypass = byp;
        out_ready  = ordy;
        cnt_clr    = clr;
        #1;
        acc = v & m_ready & ~r;
        check_val("lfsr_enable", lfsr_enable, acc & ~byp);
        check_val("in_ready", in_ready, m_ready);
        check_val("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            check_val("out_data", out_data, head[14:1]);
            check_val("out_last", out_last, head[0]);
        end
        check_val("beat_cnt", beat_cnt, m_beat);
        check_val("frame_cnt", frame_cnt, m_frame);
        en = lfsr_enable;

        if (r) begin
            exp_q.delete();
            m_beat  = 0;
            m_frame = 0;
            m_ready = 1'b0;
        end else begin
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            if (acc) begin
                if (byp) begin
                    word = d;
                end else begin
                    word   = d ^ ks_tab[ks_idx][83:70];
                    ks_idx = (ks_idx + 1) % 2048;
                end
                exp_q.push_back({word, l});
            end
            if (clr) begin
                m_beat  = 0;
                m_frame = 0;
            end else begin
                if (acc && m_beat < 65535) m_beat++;
                if (acc && l && m_frame < 65535) m_frame++;
            end
            m_ready = exp_q.size() < 2;
        end

        @(posedge clk);
        @(negedge clk);
        if (en) begin
            gen_idx = (gen_idx + 1) % 2048;
            en_pulses++;
        end
        lfsr_dout = ks_tab[gen_idx];
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 14'h0000, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [95:0] rnd;
        int          e0;
        n_checks  = 0;
        n_fail    = 0;
        gen_idx   = 0;
        ks_idx    = 0;
        en_pulses = 0;
        m_ready   = 1'b0;
        m_beat    = 0;
        m_frame   = 0;
        for (int i = 0; i < 2048; i++) begin
            rnd       = {$urandom, $urandom, $urandom};
            ks_tab[i] = rnd[83:0];
        end
        lfsr_dout  = ks_tab[0];
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 14'h0000;
        in_last    = 1'b0;
        scr_bypass = 1'b0;
        out_ready  = 1'b0;
        cnt_clr    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;

        // Reset values
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_data", out_data, 14'h0000);
        check_val("rst_out_last", out_last, 1'b0);
        check_val("rst_beat_cnt", beat_cnt, 16'h0000);
        check_val("rst_frame_cnt", frame_cnt, 16'h0000);
        check_val("rst_lfsr_enable", lfsr_enable, 1'b0);
        step(1'b1, 14'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check_val("ready_after_rst", in_ready, 1'b1);

        // Scramble a single beat with an all-ones keystream
        ks_tab[gen_idx][83:70] = 14'h3FFF;
        lfsr_dout = ks_tab[gen_idx];
        e0 = en_pulses;
        step(1'b1, 14'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("scr_data", out_data, 14'h2DCB);
        check_val("scr_valid", out_valid, 1'b1);
        idle(1'b1);
        check_val("scr_en_pulses", en_pulses - e0, 1);

        // Bypass
        step(1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        e0 = en_pulses;
        step(1'b1, 14'h0ABC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("byp_data", out_data, 14'h0ABC);
        check_val("byp_beat_cnt", beat_cnt, 16'h0001);
        idle(1'b1);
        check_val("byp_en_pulses", en_pulses - e0, 0);

        // Back-pressure: sink stalled for 4 cycles
        step(1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        e0 = en_pulses;
        step(1'b1, 14'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("bp_beat_cnt", beat_cnt, 16'h0002);
        check_val("bp_in_ready", in_ready, 1'b0);
        check_val("bp_en_pulses", en_pulses - e0, 2);
        check_val("bp_head", out_data, 14'd1 ^ ks_tab[(gen_idx + 2046) % 2048][83:70]);
        step(1'b1, 14'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("bp_second_valid", out_valid, 1'b1);
        step(1'b1, 14'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("bp_third_data", out_data, 14'd3);
        idle(1'b1);
        check_val("bp_empty", out_valid, 1'b0);
        check_val("bp_total", beat_cnt, 16'h0003);

        // Counters
        step(1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 14'($urandom), (i == 3 || i == 5), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_val("cnt_beats", beat_cnt, 16'd5);
        check_val("cnt_frames", frame_cnt, 16'd2);
        step(1'b1, 14'h0055, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("clr_beats", beat_cnt, 16'd0);
        check_val("clr_frames", frame_cnt, 16'd0);
        idle(1'b1);

        // Reset mid-stream with two beats buffered
        step(1'b1, 14'h0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'h0222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'h0333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("mid_rst_valid", out_valid, 1'b0);
        check_val("mid_rst_beats", beat_cnt, 16'd0);
        check_val("mid_rst_frames", frame_cnt, 16'd0);
        check_val("mid_rst_ready", in_ready, 1'b0);
        idle(1'b1);
        check_val("mid_rst_ready_back", in_ready, 1'b1);

        // 100 back-to-back scrambled beats
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 14'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1);

        // Random traffic with stalls, bypass toggles and clears
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 4) != 0, 14'($urandom), 1'($urandom), ($urandom % 4) == 0,
                 ($urandom % 3) != 0, ($urandom % 60) == 0, 1'b0);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Saturation of both counters
        step(1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 14'(i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check_val("sat_beats", beat_cnt, 16'hFFFF);
        check_val("sat_frames", frame_cnt, 16'hFFFF);
        step(1'b1, 14'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("sat_hold", beat_cnt, 16'hFFFF);
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
